// File: rtl/multimode_flop_reg.sv
// Multi-mode register bank: WIDTH independent bits, each acting as a D, T, JK or SR
// flop selected by a shared mode, with enable, synchronous clear, change strobe and sticky SR error.
module multimode_flop_reg #(
  parameter int          WIDTH       = 8,
  parameter logic [63:0] RESET_VALUE = 64'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             changed,
  output logic             sr_err
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  // Narrower WIDTH truncates the 64-bit parameter; a narrower override is already zero-extended.
  localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_d, q_q;
  logic             changed_d, changed_q;
  logic             sr_err_d, sr_err_q;
  logic             sr_forbid;

  assign mode_sel = mode_e'(mode);

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    q_d       = q_q;
    sr_forbid = 1'b0;
    if (clr) begin
      q_d = RST_V;
    end else if (en) begin
      case (mode_sel)
        MODE_D:  q_d = a;
        MODE_T:  q_d = q_q ^ a;
        // J sets, K clears, both toggle, neither holds.
        MODE_JK: q_d = (a & ~q_q) | (~b & q_q);
        // S=R=1 is forbidden: that bit holds, exactly like S=R=0.
        MODE_SR: begin
          q_d       = (a & ~b) | (q_q & ~(a ^ b));
          sr_forbid = |(a & b);
        end
        default: q_d = q_q;
      endcase
    end
  end

  // With en=0 and clr=0 q_d equals q_q, so the strobe falls out of the comparison.
  always_comb begin
    changed_d = (q_d != q_q);
    sr_err_d  = sr_forbid | (sr_err_q & ~err_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= RST_V;
      changed_q <= 1'b0;
      sr_err_q  <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      sr_err_q  <= sr_err_d;
    end
  end

  assign q       = q_q;
  assign qbar    = ~q_q;
  assign changed = changed_q;
  assign sr_err  = sr_err_q;

endmodule

// File: tb/tb_multimode_flop_reg.sv
// Scoreboard bench for multimode_flop_reg: directed test-plan sequence plus random stimulus,
// expected responses from a per-bit behavioural model queued and checked by a separate monitor.
module tb_multimode_flop_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, clr = 1'b0, err_clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = '0, b = '0;
  logic [7:0] q, qbar;
  logic       changed, sr_err;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] qbar;
    logic       changed;
    logic       sr_err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_q = 8'h00;
  logic       m_ch = 1'b0;
  logic       m_err = 1'b0;

  multimode_flop_reg #(.WIDTH(8), .RESET_VALUE(64'h0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
    .a(a), .b(b), .err_clr(err_clr),
    .q(q), .qbar(qbar), .changed(changed), .sr_err(sr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: each bit evaluated from the mode's truth table.
  task automatic model(input logic r, input logic e, input logic c, input logic [1:0] m,
                       input logic [7:0] aa, input logic [7:0] bb, input logic ec);
    logic [7:0] nq;
    logic       forbid;
    if (!r) begin
      m_q = 8'h00; m_ch = 1'b0; m_err = 1'b0;
      return;
    end
    nq = m_q;
    forbid = 1'b0;
    if (c) nq = 8'h00;
    else if (e) begin
      for (int i = 0; i < 8; i++) begin
        case (m)
          2'd0: nq[i] = aa[i];
          2'd1: nq[i] = aa[i] ? !m_q[i] : m_q[i];
          2'd2: begin
            if (aa[i] && bb[i]) nq[i] = !m_q[i];
            else if (aa[i])     nq[i] = 1'b1;
            else if (bb[i])     nq[i] = 1'b0;
          end
          default: begin
            if (aa[i] && !bb[i])      nq[i] = 1'b1;
            else if (bb[i] && !aa[i]) nq[i] = 1'b0;
            else if (aa[i] && bb[i])  forbid = 1'b1;
          end
        endcase
      end
    end
    m_ch = (nq != m_q);
    if (forbid) m_err = 1'b1;
    else if (ec) m_err = 1'b0;
    m_q = nq;
  endtask

  task automatic step(input logic r, input logic e, input logic c, input logic [1:0] m,
                      input logic [7:0] aa, input logic [7:0] bb, input logic ec);
    @(negedge clk);
    rst_n = r; en = e; clr = c; mode = m; a = aa; b = bb; err_clr = ec;
    model(r, e, c, m, aa, bb, ec);
    exp_q.push_back('{q: m_q, qbar: ~m_q, changed: m_ch, sr_err: m_err});
  endtask

  // Monitor: one output set per edge, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("q",       {24'h0, q},          {24'h0, e.q});
        check("qbar",    {24'h0, qbar},       {24'h0, e.qbar});
        check("changed", {31'h0, changed},    {31'h0, e.changed});
        check("sr_err",  {31'h0, sr_err},     {31'h0, e.sr_err});
      end
    end
  end

  initial begin
    int wait_cycles;
    // Power-on reset held for two edges.
    step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);

    // D/T: 3C, C3, 3C, then T with zero holds.
    step(1, 1, 0, 2'd0, 8'h3C, 8'h00, 0);
    step(1, 1, 0, 2'd1, 8'hFF, 8'h00, 0);
    step(1, 1, 0, 2'd1, 8'hFF, 8'h00, 0);
    step(1, 1, 0, 2'd1, 8'h00, 8'h00, 0);

    // Async reset mid-cycle while q=A5.
    step(1, 1, 0, 2'd0, 8'hA5, 8'h00, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_q",       {24'h0, q},       32'h00);
    check("async_rst_qbar",    {24'h0, qbar},    32'hFF);
    check("async_rst_changed", {31'h0, changed}, 32'h0);
    check("async_rst_sr_err",  {31'h0, sr_err},  32'h0);
    model(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    step(0, 1, 0, 2'd0, 8'hFF, 8'h00, 0);
    // Release and load on the first edge.
    step(1, 1, 0, 2'd0, 8'h12, 8'h00, 0);

    // JK.
    step(1, 1, 0, 2'd0, 8'h0F, 8'h00, 0);
    step(1, 1, 0, 2'd2, 8'hF0, 8'h0F, 0);
    step(1, 1, 0, 2'd2, 8'hFF, 8'hFF, 0);
    step(1, 1, 0, 2'd2, 8'h00, 8'h00, 0);

    // SR forbidden and sticky error.
    step(1, 0, 1, 2'd0, 8'h00, 8'h00, 0);
    step(1, 1, 0, 2'd3, 8'h81, 8'h01, 0);
    step(1, 1, 0, 2'd3, 8'h00, 8'h00, 0);
    step(1, 1, 0, 2'd3, 8'h01, 8'h01, 1);
    step(1, 1, 0, 2'd3, 8'h00, 8'h00, 1);

    // Enable/clear priority.
    step(1, 1, 0, 2'd0, 8'h55, 8'h00, 0);
    step(1, 0, 0, 2'd0, 8'hFF, 8'h00, 0);
    step(1, 0, 1, 2'd0, 8'hFF, 8'h00, 0);
    step(1, 1, 0, 2'd0, 8'h3A, 8'h00, 0);
    step(1, 1, 1, 2'd3, 8'hFF, 8'hFF, 0);

    // Random traffic with occasional clear, error clear and reset.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 11) == 0), 2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0));
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
